// File: rtl/efuse_aen_seq.sv
// efuse_aen_seq: sequences one timed AEN strobe (setup/strobe/hold) per selected bit of an eFuse word,
// with manual AEN passthrough when idle and no valid mode is selected.
module efuse_aen_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 10,
    localparam int BIT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cfg_tsu,
    input  logic [CNT_W-1:0]  cfg_tpgm,
    input  logic [CNT_W-1:0]  cfg_trd,
    input  logic [CNT_W-1:0]  cfg_thd,
    input  logic              refresh,
    input  logic              pgmen,
    input  logic              rden,
    input  logic              aen_manual,
    input  logic              abort,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              efuse_aen,
    output logic [ADDR_W-1:0] efuse_addr,
    output logic [BIT_W-1:0]  efuse_bitsel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [BIT_W:0]    pulse_cnt
);
    typedef enum logic [2:0] {IDLE, SEL, SETUP, STROBE, HOLD} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q, tsu_q, tstb_q, thd_q;
    logic [DATA_W-1:0] mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BIT_W-1:0]  bitsel_q, low_bit;
    logic [BIT_W:0]    pcnt_q;
    logic              aen_q, done_q, err_q, last;

    function automatic logic [CNT_W-1:0] at_least_1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // lowest set bit of the remaining mask
    always_comb begin
        low_bit = '0;
        for (int i = DATA_W - 1; i >= 0; i--)
            if (mask_q[i]) low_bit = BIT_W'(i);
    end

    assign last = cnt_q == CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tsu_q    <= '0;
            tstb_q   <= '0;
            thd_q    <= '0;
            mask_q   <= '0;
            addr_q   <= '0;
            bitsel_q <= '0;
            pcnt_q   <= '0;
            aen_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // AEN trails the FSM by one register stage; abort kills it on the same edge
            aen_q <= (state_q != IDLE) ? (state_q == STROBE && !abort) : (pgmen == rden && aen_manual);
            if (state_q != IDLE && abort) begin
                state_q <= IDLE;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (refresh) begin
                        if (pgmen ^ rden) begin
                            state_q <= SEL;
                            addr_q  <= addr;
                            tsu_q   <= at_least_1(cfg_tsu);
                            tstb_q  <= at_least_1(pgmen ? cfg_tpgm : cfg_trd);
                            thd_q   <= at_least_1(cfg_thd);
                            mask_q  <= pgmen ? wdata : '1;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            pcnt_q  <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    SEL: if (mask_q == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= SETUP;
                        bitsel_q <= low_bit;
                        mask_q   <= mask_q & ~(DATA_W'(1) << low_bit);
                        cnt_q    <= tsu_q;
                    end
                    SETUP: if (last) begin
                        state_q <= STROBE;
                        cnt_q   <= tstb_q;
                        pcnt_q  <= pcnt_q + (BIT_W+1)'(1);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    STROBE: if (last) begin
                        state_q <= HOLD;
                        cnt_q   <= thd_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    HOLD: if (last) begin
                        state_q <= SEL;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign efuse_aen    = aen_q;
    assign efuse_addr   = addr_q;
    assign efuse_bitsel = bitsel_q;
    assign busy         = state_q != IDLE;
    assign done         = done_q;
    assign err          = err_q;
    assign pulse_cnt    = pcnt_q;
endmodule

// File: tb/tb_efuse_aen_seq.sv
// tb_efuse_aen_seq: directed and randomized sequences checked against a pulse-timing model of the eFuse AEN sequencer.
module tb_efuse_aen_seq;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 10;
    localparam int BIT_W  = 3;

    logic              clk = 1'b0, rst = 1'b1;
    logic [CNT_W-1:0]  cfg_tsu = '0, cfg_tpgm = '0, cfg_trd = '0, cfg_thd = '0;
    logic              refresh = 1'b0, pgmen = 1'b0, rden = 1'b0, aen_manual = 1'b0, abort = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              efuse_aen, busy, done, err;
    logic [ADDR_W-1:0] efuse_addr;
    logic [BIT_W-1:0]  efuse_bitsel;
    logic [BIT_W:0]    pulse_cnt;

    efuse_aen_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_tsu(cfg_tsu), .cfg_tpgm(cfg_tpgm), .cfg_trd(cfg_trd), .cfg_thd(cfg_thd),
        .refresh(refresh), .pgmen(pgmen), .rden(rden), .aen_manual(aen_manual), .abort(abort),
        .addr(addr), .wdata(wdata),
        .efuse_aen(efuse_aen), .efuse_addr(efuse_addr), .efuse_bitsel(efuse_bitsel),
        .busy(busy), .done(done), .err(err), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0, passed = 0, failed = 0, total = 0, busy_cyc = 0, rise_at = 0, nref = 0;
    int rises[$], widths[$], bits[$];
    logic prev_aen = 1'b0;

    always @(posedge clk) cyc++;

    // record every AEN pulse as (rise cycle, width, bit) and count busy cycles
    always @(negedge clk) begin
        if (efuse_aen === 1'b1 && !prev_aen) begin
            rises.push_back(cyc);
            bits.push_back(int'(efuse_bitsel));
            rise_at = cyc;
        end
        if (efuse_aen !== 1'b1 && prev_aen) widths.push_back(cyc - rise_at);
        prev_aen = (efuse_aen === 1'b1);
        if (busy === 1'b1) busy_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input bit rd, input logic [7:0] a, input logic [7:0] wd,
                         input int tsu, input int w, input int thd, input bit ab);
        @(negedge clk);
        pgmen   = !rd;
        rden    = rd;
        addr    = a;
        wdata   = wd;
        cfg_tsu = CNT_W'(tsu);
        cfg_thd = CNT_W'(thd);
        cfg_tpgm = rd ? CNT_W'($urandom_range(1, 9)) : CNT_W'(w);
        cfg_trd  = rd ? CNT_W'(w) : CNT_W'($urandom_range(1, 9));
        aen_manual = 1'b0;
        abort   = ab;
        refresh = 1'b1;
        @(posedge clk);
        #1;
        nref = cyc;
        rises.delete();
        widths.delete();
        bits.delete();
        busy_cyc = 0;
        refresh = 1'b0;
        abort   = 1'b0;
    endtask

    task automatic finish_seq(input bit rd, input logic [7:0] a, input logic [7:0] wd,
                              input int tsu, input int w, input int thd, input bit jit);
        int ts, ws, th, per, k, j, b, budget, lastbit;
        logic [7:0] mask;
        ts = (tsu == 0) ? 1 : tsu;
        ws = (w == 0) ? 1 : w;
        th = (thd == 0) ? 1 : thd;
        per = 1 + ts + ws + th;
        mask = rd ? 8'hFF : wd;
        k = $countones(mask);
        budget = k * per + 20;
        b = 0;
        do begin
            @(negedge clk);
            b++;
            if (jit && busy === 1'b1) begin
                refresh  = 1'($urandom);
                cfg_tsu  = CNT_W'($urandom);
                cfg_tpgm = CNT_W'($urandom);
                cfg_trd  = CNT_W'($urandom);
                cfg_thd  = CNT_W'($urandom);
                addr     = ADDR_W'($urandom);
                wdata    = DATA_W'($urandom);
                aen_manual = 1'($urandom);
            end
        end while (busy === 1'b1 && b < budget);
        refresh = 1'b0;
        aen_manual = 1'b0;
        chk("seq_end_in_time", 32'(b < budget), 32'd1);
        chk("pulse_count_seen", rises.size(), k);
        chk("fall_count_seen", widths.size(), k);
        j = 0;
        lastbit = 0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                if (j < rises.size()) chk($sformatf("rise%0d", j), rises[j], nref + 2 + ts + j * per);
                if (j < widths.size()) chk($sformatf("width%0d", j), widths[j], ws);
                if (j < bits.size()) chk($sformatf("bitsel%0d", j), bits[j], i);
                lastbit = i;
                j++;
            end
        end
        chk("busy_cycles", busy_cyc, k * per + 1);
        chk("efuse_addr", efuse_addr, a);
        chk("pulse_cnt", pulse_cnt, k);
        chk("done", done, 1);
        chk("err", err, 0);
        chk("aen_idle", efuse_aen, 0);
        if (k > 0) chk("bitsel_hold", efuse_bitsel, lastbit);
    endtask

    task automatic run_seq(input bit rd, input logic [7:0] a, input logic [7:0] wd,
                           input int tsu, input int w, input int thd, input bit ab, input bit jit);
        start(rd, a, wd, tsu, w, thd, ab);
        finish_seq(rd, a, wd, tsu, w, thd, jit);
    endtask

    initial begin
        bit rd, ab, m;
        logic [7:0] a, wd;
        int tsu, w, thd, b;

        repeat (3) @(negedge clk);
        chk("rst_aen", efuse_aen, 0);
        chk("rst_addr", efuse_addr, 0);
        chk("rst_bitsel", efuse_bitsel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pcnt", pulse_cnt, 0);
        rst = 1'b0;

        // program 0x81 at 0x3A, then read with minimal timing
        run_seq(0, 8'h3A, 8'h81, 2, 5, 3, 0, 0);
        run_seq(1, 8'hC4, 8'h00, 1, 1, 1, 0, 0);
        // degenerate cases: empty mask, zero strobe width, max strobe width
        run_seq(0, 8'h11, 8'h00, 3, 4, 2, 0, 0);
        run_seq(0, 8'h22, 8'h5A, 0, 0, 0, 0, 0);
        run_seq(0, 8'h33, 8'h10, 0, 1023, 0, 0, 0);

        // abort in idle: no flag effect
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_err", err, 0);
        chk("idle_abort_done", done, 1);
        chk("idle_abort_busy", busy, 0);

        // illegal request with both modes set
        pgmen = 1'b1;
        rden  = 1'b1;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        chk("illegal_err", err, 1);
        chk("illegal_busy", busy, 0);

        // manual passthrough, one register stage
        aen_manual = 1'b1;
        #1 chk("manual_not_comb", efuse_aen, 0);
        @(negedge clk);
        chk("manual_hi", efuse_aen, 1);
        for (int i = 0; i < 6; i++) begin
            m = 1'($urandom);
            aen_manual = m;
            if (i == 3) begin
                pgmen = 1'b0;
                rden  = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("manual%0d", i), efuse_aen, m);
        end
        aen_manual = 1'b1;
        pgmen = 1'b1;
        @(negedge clk);
        chk("manual_masked_valid_mode", efuse_aen, 0);
        aen_manual = 1'b0;

        // randomized sequences with input jitter while busy, some with abort+refresh at start
        for (int n = 0; n < 8; n++) begin
            rd  = 1'($urandom);
            ab  = 1'($urandom);
            a   = 8'($urandom);
            wd  = 8'($urandom);
            tsu = $urandom_range(0, 4);
            w   = $urandom_range(0, 6);
            thd = $urandom_range(0, 4);
            run_seq(rd, a, wd, tsu, w, thd, ab, 1);
        end

        // abort during the 3rd cycle of the 2nd strobe
        start(0, 8'h55, 8'hFF, 2, 5, 3, 0);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (cyc < nref + 17 && b < 100);
        chk("abort_reach", 32'(b < 100), 32'd1);
        chk("abort_in_strobe", efuse_aen, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_aen", efuse_aen, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 1);
        chk("abort_done", done, 0);
        chk("abort_pcnt", pulse_cnt, 2);
        chk("abort_pulses", rises.size(), 2);

        // reset in the middle of a strobe, then a clean restart
        start(0, 8'hA5, 8'h0F, 1, 6, 1, 0);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (efuse_aen !== 1'b1 && b < 50);
        chk("rst_mid_reach", 32'(b < 50), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstm_aen", efuse_aen, 0);
        chk("rstm_addr", efuse_addr, 0);
        chk("rstm_bitsel", efuse_bitsel, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_done", done, 0);
        chk("rstm_err", err, 0);
        chk("rstm_pcnt", pulse_cnt, 0);
        rst = 1'b0;
        run_seq(0, 8'h7E, 8'h24, 1, 2, 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/efuse_aen_seq.md
Name: efuse_aen_seq

Overview:
- Parametrised successor of the single-pulse eFuse AEN generator.
- Sequences a whole eFuse word per request. Issues one timed AEN strobe per selected bit, each with setup, strobe and hold phases.
- Program mode strobes only the bits set in the write data. Read mode strobes every bit.
- Sits between the eFuse register file and the eFuse macro pins. When idle with no valid mode, passes the manual AEN register straight through.

Parameters:
ADDR_W, 8, eFuse word address width
DATA_W, 8, bits per word; BIT_W = $clog2(DATA_W)
CNT_W, 10, width of all timing configuration fields

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
cfg_tsu  in  CNT_W  setup cycles before each strobe (0 treated as 1)
cfg_tpgm  in  CNT_W  program strobe width in cycles (0 treated as 1)
cfg_trd  in  CNT_W  read strobe width in cycles (0 treated as 1)
cfg_thd  in  CNT_W  hold cycles after each strobe (0 treated as 1)
refresh  in  1  start request, sampled each cycle
pgmen  in  1  program mode select
rden  in  1  read mode select
aen_manual  in  1  manual AEN, used when idle and pgmen==rden
abort  in  1  terminate the sequence in progress
addr  in  ADDR_W  word address
wdata  in  DATA_W  program bit mask
efuse_aen  out  1  AEN to the macro
efuse_addr  out  ADDR_W  latched word address
efuse_bitsel  out  BIT_W  bit currently being strobed
busy  out  1  sequence active
done  out  1  sticky: last sequence completed normally
err  out  1  sticky: illegal request or abort
pulse_cnt  out  BIT_W+1  strobes issued in the current or last sequence

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: every output is 0. FSM goes to IDLE. Internal latches are cleared.
- Start acceptance:
  - A start is accepted when the FSM is in IDLE, refresh=1, and pgmen^rden=1.
  - On accept, the block latches: addr, the mode, all four cfg values, and the bit mask.
  - The mask is wdata in program mode and all-ones in read mode.
  - The same accept clears done, err and pulse_cnt. busy=1 from the next cycle.
- Illegal request: refresh=1 in IDLE with pgmen==rden sets err. There is no start.
- Refresh while busy is ignored and has no flag effect.
- FSM states: IDLE, SEL, SETUP, STROBE, HOLD.
- SEL (1 cycle):
  - If the remaining mask is zero, go to IDLE, set done, and clear busy.
  - Otherwise pick the lowest set bit into efuse_bitsel, clear that bit in the mask, and go to SETUP.
- SETUP: lasts max(tsu,1) cycles, then goes to STROBE.
- STROBE:
  - efuse_aen=1 for exactly max(tpgm,1) cycles in program mode, or max(trd,1) cycles in read mode.
  - pulse_cnt increments on entry.
  - Then goes to HOLD.
- HOLD: lasts max(thd,1) cycles, then goes to SEL.
- Latency: refresh accepted at edge N → SEL at N+1 → first efuse_aen high at N+2+tsu.
- A program request with wdata=0 gives: busy for 1 cycle, done set, no strobe.
- Abort:
  - abort=1 while busy forces IDLE on the next edge, and efuse_aen drops on that same edge.
  - Sets err; done stays 0. pulse_cnt holds its value.
  - Abort in IDLE has no effect.
  - If abort and refresh arrive together in IDLE, the start is accepted.
- Timing counter:
  - CNT_W bits; reloads on every state entry and counts down to 1.
  - The max-value configuration (2^CNT_W-1) must work with no wrap.
- efuse_aen output mux:
  - busy=1: FSM strobe.
  - idle with pgmen==rden: aen_manual.
  - Otherwise 0.
  - efuse_aen is a registered output and must be glitch-free.
- Config and input changes: changes to cfg, addr or wdata while busy have no effect on the sequence in progress.
- efuse_addr and efuse_bitsel hold their last values after completion.
- Reset mid-sequence: efuse_aen=0 on the next edge and all state is cleared.

Test Plan:
- Program: tsu=2, tpgm=5, thd=3, addr=0x3A, wdata=0x81 → two 5-cycle AEN pulses, bitsel 0 then 7, efuse_addr=0x3A, pulse_cnt=2, done=1, err=0. First AEN rise 4 cycles after the refresh edge. Pulses are separated by thd+1+tsu=6 low cycles.
- Read: DATA_W=8, trd=1, all cfg=1 → 8 single-cycle pulses on bitsel 0..7, pulse_cnt=8, done=1.
- Illegal and manual passthrough:
  - pgmen=rden=1 with refresh → err=1, busy stays 0.
  - aen_manual toggling appears on efuse_aen 1 cycle later.
- Abort: abort during the 3rd cycle of the 2nd strobe, wdata=0xFF → efuse_aen low next edge, busy=0, err=1, done=0, pulse_cnt=2.
- Edge cases:
  - wdata=0 program → done in 1 busy cycle, no AEN.
  - cfg_tpgm=0 → 1-cycle strobe.
  - cfg_tpgm=1023 → exactly 1023-cycle strobe.
- Robustness:
  - Refresh and cfg changes while busy → ignored.
  - rst asserted mid-STROBE → all outputs 0 next edge.
  - New start after reset works normally.
